// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per bus master.
// The requester drives the master modport; the arbiter takes the slave modport.
interface mem_arbiter_if #(
    parameter int unsigned DBITS = 16
);
    logic             req;
    logic             we;
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             gnt;
    logic             done;
    logic [DBITS-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  done,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output done,
        output rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and address decoder in front of the single-port
// MEM array and the KEY/SW registers; each access takes IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int unsigned DBITS = 16,
    parameter int unsigned ABITS = 12
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     cpu,
    mem_arbiter_if.slave     dma,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_din,
    output logic             mem_we,
    input  logic [DBITS-1:0] mem_dout,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic             busy
);
    localparam int unsigned WBITS = DBITS - 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [DBITS-1:0] KEY_ADDR = DBITS'(16'h0FF0);
    localparam logic [DBITS-1:0] SW_ADDR  = DBITS'(16'h0FF2);
    localparam logic [DBITS-1:0] DEAD_VAL = DBITS'(16'hDEAD);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             pick_dma;
    logic             enter_access;

    logic             last_dma;
    logic             sel_dma;
    logic             lat_we;
    logic [WBITS-1:0] lat_waddr;
    logic [DBITS-1:0] lat_wdata;

    logic             cpu_gnt_q;
    logic             dma_gnt_q;
    logic             cpu_done_q;
    logic             dma_done_q;
    logic             busy_q;
    logic [DBITS-1:0] cpu_rdata_q;
    logic [DBITS-1:0] dma_rdata_q;

    logic             key_hit;
    logic             sw_hit;
    logic             io_hit;
    logic             mem_en;
    logic [DBITS-1:0] rd_val;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; on a tie the port not served last wins
    always_comb begin
        state_nx     = state;
        enter_access = 1'b0;
        pick_dma     = dma.req & (~cpu.req | ~last_dma);
        case (state)
            ST_IDLE: begin
                if (cpu.req | dma.req) begin
                    state_nx     = ST_ACCESS;
                    enter_access = 1'b1;
                end
            end
            ST_ACCESS: state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Address decode of the latched word address; I/O wins over the memory window
    always_comb begin
        key_hit = (lat_waddr == KEY_ADDR[DBITS-1:1]);
        sw_hit  = (lat_waddr == SW_ADDR[DBITS-1:1]);
        io_hit  = key_hit | sw_hit;
        mem_en  = (lat_waddr[WBITS-1:ABITS] == '0);
        if (key_hit) begin
            rd_val = DBITS'(key);
        end else if (sw_hit) begin
            rd_val = DBITS'(sw);
        end else if (mem_en) begin
            rd_val = mem_dout;
        end else begin
            rd_val = DEAD_VAL;
        end
    end

    // Request latch, handshake flags and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dma    <= 1'b1;
            sel_dma     <= 1'b0;
            lat_we      <= 1'b0;
            lat_waddr   <= '0;
            lat_wdata   <= '0;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            cpu_gnt_q  <= enter_access & ~pick_dma;
            dma_gnt_q  <= enter_access & pick_dma;
            cpu_done_q <= (state == ST_ACCESS) & ~sel_dma;
            dma_done_q <= (state == ST_ACCESS) & sel_dma;
            busy_q     <= (state_nx != ST_IDLE);
            if (enter_access) begin
                sel_dma  <= pick_dma;
                last_dma <= pick_dma;
                if (pick_dma) begin
                    lat_we    <= dma.we;
                    lat_waddr <= dma.addr[DBITS-1:1];
                    lat_wdata <= dma.wdata;
                end else begin
                    lat_we    <= cpu.we;
                    lat_waddr <= cpu.addr[DBITS-1:1];
                    lat_wdata <= cpu.wdata;
                end
            end
            if ((state == ST_ACCESS) && !lat_we) begin
                if (sel_dma) begin
                    dma_rdata_q <= rd_val;
                end else begin
                    cpu_rdata_q <= rd_val;
                end
            end
        end
    end

    // Reset gates the strobe directly so a write is killed in the cycle reset arrives
    assign mem_we   = (state == ST_ACCESS) & lat_we & mem_en & ~io_hit & ~reset;
    assign mem_addr = lat_waddr[ABITS-1:0];
    assign mem_din  = lat_wdata;
    assign busy     = busy_q;

    assign cpu.gnt   = cpu_gnt_q;
    assign cpu.done  = cpu_done_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dma.gnt   = dma_gnt_q;
    assign dma.done  = dma_done_q;
    assign dma.rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses with a read-data scoreboard,
// plus hand sequences for tie alternation and reset in ACCESS / RESP.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic [15:0] mem_dout;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic        busy;

    logic [15:0] mem [4096];

    mem_arbiter_if #(.DBITS(16)) cpu_if ();
    mem_arbiter_if #(.DBITS(16)) dma_if ();

    mem_arbiter #(.DBITS(16), .ABITS(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (cpu_if),
        .dma      (dma_if),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .key      (key),
        .sw       (sw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural MEM: asynchronous read, synchronous write
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    typedef struct {
        bit          dma;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        bit          exp_we;
    } vec_t;

    localparam int NVEC = 15;
    vec_t        vecs [NVEC];
    logic [15:0] exp_q [$];
    logic [15:0] prev_rd [2];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit dma, input bit req, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (dma) begin
            dma_if.req = req; dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wdata;
        end else begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) step();
        reset = 1'b0;
        prev_rd[0] = 16'h0;
        prev_rd[1] = 16'h0;
    endtask

    // One access through the full handshake; rdata is checked against the scoreboard
    task automatic run_vec(input vec_t v);
        logic [15:0] exp;
        logic [1:0]  gnts;
        logic [2:0]  dones;
        logic [15:0] rd;
        exp = v.we ? prev_rd[v.dma] : v.exp_rd;
        if (!v.we) prev_rd[v.dma] = v.exp_rd;
        @(negedge clk);
        drive(v.dma, 1'b1, v.we, v.addr, v.wdata);
        exp_q.push_back(exp);
        step();
        gnts = v.dma ? {dma_if.gnt, cpu_if.gnt} : {cpu_if.gnt, dma_if.gnt};
        check("gnt_access", 32'(gnts), 32'(2'b10));
        check("mem_we_access", 32'(mem_we), 32'(v.exp_we));
        if (v.exp_we) check("mem_addr", 32'(mem_addr), 32'(v.addr[12:1]));
        step();
        dones = v.dma ? {dma_if.done, cpu_if.done, dma_if.gnt} : {cpu_if.done, dma_if.done, cpu_if.gnt};
        check("done_resp", 32'(dones), 32'(3'b100));
        check("mem_we_resp", 32'(mem_we), 32'(0));
        rd = v.dma ? dma_if.rdata : cpu_if.rdata;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty: got %h expected none", rd);
        end else begin
            check("rdata", 32'(rd), 32'(exp_q.pop_front()));
        end
        drive(v.dma, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check("idle_after", 32'({busy, cpu_if.done, dma_if.done}), 32'(0));
    endtask

    initial begin
        logic [3:0] exp4;
        logic [3:0] act4;
        vec_t       v;
        int         ph;
        int         w;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h100] = 16'h1234;
        mem[12'h008] = 16'h7777;
        key = 4'b1010;
        sw  = 10'h155;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        vecs[0]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h000A, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0FF2, 16'h0000, 16'h0155, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'hDEAD, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0FF0, 16'h1111, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 16'h0FF2, 16'h2222, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h4000, 16'h3333, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0201, 16'h0000, 16'h1234, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'h1FFE, 16'h5A5A, 16'h0000, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 16'h1FFE, 16'h0000, 16'h5A5A, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h2000, 16'h0000, 16'hDEAD, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'h0FF1, 16'h0000, 16'h000A, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};

        do_reset();
        check("reset_flags", 32'({cpu_if.gnt, cpu_if.done, dma_if.gnt, dma_if.done, mem_we, busy}), 32'(0));
        check("reset_mem_bus", {4'h0, mem_addr, mem_din}, 32'(0));
        check("reset_rdata", {cpu_if.rdata, dma_if.rdata}, 32'(0));

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Both ports requesting continuously: grants alternate, CPU first after reset
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0FF2, 16'h0);
        for (int k = 0; k < 12; k++) begin
            step();
            ph = k % 3;
            w  = (k / 3) % 2;
            exp4 = {ph == 0 && w == 0, ph == 1 && w == 0, ph == 0 && w == 1, ph == 1 && w == 1};
            act4 = {cpu_if.gnt, cpu_if.done, dma_if.gnt, dma_if.done};
            check("alternate", 32'(act4), 32'(exp4));
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("alt_rdata", {cpu_if.rdata, dma_if.rdata}, {16'h1234, 16'h0155});
        step();

        // Reset arriving in the ACCESS cycle of a CPU write
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'hCAFE);
        step();
        check("rst_acc_gnt", 32'(cpu_if.gnt), 32'(1));
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        check("rst_acc_we", 32'(mem_we), 32'(0));
        step();
        check("rst_acc_idle", 32'({cpu_if.done, cpu_if.gnt, busy}), 32'(0));
        reset = 1'b0;
        check("rst_acc_mem", 32'(mem[12'h008]), 32'(16'h7777));
        v = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h7777, 1'b0};
        run_vec(v);

        // Reset arriving in the RESP cycle of a CPU read
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
        step();
        step();
        check("rst_resp_done", 32'({cpu_if.done, cpu_if.rdata}), {15'h0, 1'b1, 16'h1234});
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check("rst_resp_clear", 32'({cpu_if.done, busy, cpu_if.rdata}), 32'(0));
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
